// File: rtl/relu_maxpool.sv
// relu_maxpool: streaming ReLU + 2x2/stride-2 max-pool over an m x m raster map.
// Ports: clk, global_rst (sync, active-high), ce, conv_op[31:0] signed,
//        valid_conv in; pool_op[31:0] (>=0), valid_pool pulse, end_pool sticky out.
module relu_maxpool #(
    parameter int m = 8
) (
    input  logic        clk,
    input  logic        global_rst,
    input  logic        ce,
    input  logic [31:0] conv_op,
    input  logic        valid_conv,
    output logic [31:0] pool_op,
    output logic        valid_pool,
    output logic        end_pool
);

    localparam int CW   = $clog2(m);
    localparam int HALF = m / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [31:0]   hreg_q, hreg_d;
    logic [31:0]   rowbuf_q [HALF];
    logic [31:0]   rowbuf_d [HALF];
    logic [31:0]   pool_q, pool_d;
    logic          valid_q, valid_d;
    logic          end_q, end_d;

    logic          acc;
    logic          last_col;
    logic          last_row;
    logic [31:0]   v;
    logic [31:0]   pair;
    logic [HW-1:0] idx;

    function automatic logic [31:0] umax(input logic [31:0] a,
                                         input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    // Once the map is complete, further input is ignored until reset.
    assign acc      = ce & valid_conv & ~end_q;
    assign last_col = (col_q == CW'(m - 1));
    assign last_row = (row_q == CW'(m - 1));
    assign v        = conv_op[31] ? 32'd0 : conv_op;
    assign pair     = umax(hreg_q, v);
    assign idx      = HW'(col_q >> 1);

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        hreg_d   = hreg_q;
        rowbuf_d = rowbuf_q;
        pool_d   = pool_q;
        valid_d  = 1'b0;
        end_d    = end_q;
        if (acc) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!col_q[0]) begin
                hreg_d = v;
            end else if (!row_q[0]) begin
                // Even row: park the horizontal pair max for the row below.
                rowbuf_d[idx] = pair;
            end else begin
                pool_d  = umax(rowbuf_q[idx], pair);
                valid_d = 1'b1;
                end_d   = last_row & last_col;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            hreg_q  <= '0;
            pool_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            for (int i = 0; i < HALF; i++) begin
                rowbuf_q[i] <= '0;
            end
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            hreg_q   <= hreg_d;
            rowbuf_q <= rowbuf_d;
            pool_q   <= pool_d;
            valid_q  <= valid_d;
            end_q    <= end_d;
        end
    end

    assign pool_op    = pool_q;
    assign valid_pool = valid_q;
    assign end_pool   = end_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: table-driven, directed and random checks of relu_maxpool
// against a whole-map reference model.
module tb_relu_maxpool;

    localparam int M = 8;

    logic        clk = 1'b0;
    logic        global_rst = 1'b0;
    logic        ce = 1'b0;
    logic [31:0] conv_op = '0;
    logic        valid_conv = 1'b0;
    logic [31:0] pool_op;
    logic        valid_pool;
    logic        end_pool;

    relu_maxpool #(.m(M)) dut (
        .clk        (clk),
        .global_rst (global_rst),
        .ce         (ce),
        .conv_op    (conv_op),
        .valid_conv (valid_conv),
        .pool_op    (pool_op),
        .valid_pool (valid_pool),
        .end_pool   (end_pool)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: stores the whole map, pools 2x2 blocks directly.
    logic [31:0] pix [M][M];
    int          mr, mc;
    bit          ev, ee;
    logic [31:0] ep;
    logic [31:0] got [$];

    typedef struct {
        logic [31:0] data;
        bit          ev;
        logic [31:0] ep;
        bit          ee;
    } vec_t;
    vec_t tbl [M*M];

    function automatic logic [31:0] relu(input logic [31:0] x);
        return x[31] ? 32'd0 : x;
    endfunction

    function automatic logic [31:0] max4(input logic [31:0] a, b, c, d);
        logic [31:0] r;
        r = a;
        if (b > r) r = b;
        if (c > r) r = c;
        if (d > r) r = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit v,
                        input logic [31:0] d, output bit accepted);
        global_rst = r;
        ce         = e;
        valid_conv = v;
        conv_op    = d;
        @(posedge clk);
        #1;
        accepted = 1'b0;
        ev       = 1'b0;
        if (r) begin
            mr = 0; mc = 0; ep = '0; ee = 1'b0;
        end else if (e && v && !ee) begin
            accepted    = 1'b1;
            pix[mr][mc] = relu(d);
            if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                ep = max4(pix[mr-1][mc-1], pix[mr-1][mc],
                          pix[mr][mc-1], pix[mr][mc]);
                ev = 1'b1;
                if (mr == M - 1 && mc == M - 1) ee = 1'b1;
            end
            mc++;
            if (mc == M) begin
                mc = 0;
                mr = (mr == M - 1) ? 0 : mr + 1;
            end
        end
        chk("valid_pool", {31'd0, valid_pool}, {31'd0, ev});
        chk("pool_op", pool_op, ep);
        chk("end_pool", {31'd0, end_pool}, {31'd0, ee});
        if (valid_pool) got.push_back(pool_op);
    endtask

    task automatic do_reset();
        bit a;
        step(1'b1, 1'b0, 1'b0, 32'd0, a);
        got.delete();
    endtask

    task automatic send_ramp();
        bit a;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++)
                step(1'b0, 1'b1, 1'b1, 32'(8 * r + c), a);
    endtask

    task automatic chk_ramp(input string name);
        chk({name, "_count"}, 32'(got.size()), 32'd16);
        for (int i = 0; i < got.size() && i < 16; i++)
            chk(name, got[i], 32'(16 * (i / 4) + 2 * (i % 4) + 9));
    endtask

    initial begin
        bit a;
        logic [31:0] d;

        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
                tbl[r*M+c].data = 32'(8 * r + c);
                tbl[r*M+c].ev   = (r % 2 == 1) && (c % 2 == 1);
                tbl[r*M+c].ee   = (r == M - 1) && (c == M - 1);
                if (tbl[r*M+c].ev)
                    tbl[r*M+c].ep = 32'(16 * (r / 2) + 2 * (c / 2) + 9);
                else if (r * M + c == 0 || r < 1)
                    tbl[r*M+c].ep = 32'd0;
                else
                    tbl[r*M+c].ep = tbl[r*M+c-1].ep;
            end
        end

        mr = 0; mc = 0; ev = 0; ee = 0; ep = '0;

        // Reset state
        do_reset();
        chk("rst_pool", pool_op, 32'd0);
        chk("rst_valid", {31'd0, valid_pool}, 32'd0);
        chk("rst_end", {31'd0, end_pool}, 32'd0);

        // Test 1: ramp map from table
        for (int i = 0; i < M * M; i++) begin
            step(1'b0, 1'b1, 1'b1, tbl[i].data, a);
            chk("tbl_valid", {31'd0, valid_pool}, {31'd0, tbl[i].ev});
            chk("tbl_pool", pool_op, tbl[i].ep);
            chk("tbl_end", {31'd0, end_pool}, {31'd0, tbl[i].ee});
        end
        chk_ramp("ramp");

        // Test 5: input after end of map is ignored
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'd1000, a);
            chk("post_pool", pool_op, 32'd63);
            chk("post_valid", {31'd0, valid_pool}, 32'd0);
            chk("post_end", {31'd0, end_pool}, 32'd1);
        end

        // Test 2: ReLU
        do_reset();
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
                d = 32'hFFFF_FFFB;
                if (r == 0 && c == 0) d = 32'd7;
                if (r == 3 && c == 3) d = 32'h7FFF_FFFF;
                step(1'b0, 1'b1, 1'b1, d, a);
            end
        end
        chk("relu_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < got.size() && i < 16; i++)
            chk("relu_val", got[i],
                (i == 0) ? 32'd7 : (i == 5) ? 32'h7FFF_FFFF : 32'd0);

        // Test 3: row gaps and ce toggling
        do_reset();
        begin
            bit tog = 1'b1;
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < M; c++) begin
                    a = 1'b0;
                    for (int t = 0; t < 4 && !a; t++) begin
                        step(1'b0, tog, 1'b1, 32'(8 * r + c), a);
                        tog = ~tog;
                    end
                    chk("gap_accept", {31'd0, a}, 32'd1);
                end
                for (int g = 0; g < 2; g++) begin
                    step(1'b0, tog, 1'b0, 32'd0, a);
                    tog = ~tog;
                end
            end
        end
        chk_ramp("gap");

        // Test 4: mid-map reset
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b1, 32'(1000 + i), a);
        step(1'b1, 1'b1, 1'b0, 32'd0, a);
        chk("mrst_valid", {31'd0, valid_pool}, 32'd0);
        chk("mrst_pool", pool_op, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0, a);
        chk("mrst_valid2", {31'd0, valid_pool}, 32'd0);
        got.delete();
        send_ramp();
        chk_ramp("mrst");

        // Test 6: reset wins over an accepted pixel
        do_reset();
        for (int i = 0; i < M + 1; i++)
            step(1'b0, 1'b1, 1'b1, 32'd5, a);
        step(1'b1, 1'b1, 1'b1, 32'd99, a);
        chk("prio_valid", {31'd0, valid_pool}, 32'd0);
        chk("prio_pool", pool_op, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, a);
        chk("prio_valid2", {31'd0, valid_pool}, 32'd0);
        chk("prio_pool2", pool_op, 32'd0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            d = ($urandom_range(0, 1) == 1) ? $urandom
                                            : 32'($urandom_range(0, 15));
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, d, a);
            if (ee && $urandom_range(0, 9) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Streaming ReLU plus 2x2/stride-2 max-pooling stage directly downstream of the convolver. It consumes the raster-ordered `conv_op`/`valid_conv` stream of one m x m feature map and emits (m/2) x (m/2) pooled results in raster order. A one-row buffer of horizontal pair maxima makes each pooled result available one cycle after its last contributing pixel.

## Interface
- `m`, default 8: feature-map width and height in pixels. This equals n-k+1 of the convolver (n=10, k=3). Must be even, with 2 ≤ m ≤ 256.
- `clk` input 1: rising-edge clock.
- `global_rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `ce` input 1: clock enable. A pixel is accepted only when `ce` and `valid_conv` are both 1.
- `conv_op` input 32: convolver result, signed two's complement.
- `valid_conv` input 1: `conv_op` carries a valid feature-map pixel this cycle.
- `pool_op` output 32: pooled result, signed, always ≥ 0.
- `valid_pool` output 1: `pool_op` is valid. Single-cycle pulse.
- `end_pool` output 1: the last pooled result of the map has been emitted. Sticky until reset.

## Operation
**Accept.** On a cycle with `ce`=1, `valid_conv`=1 and `end_pool`=0, the block takes one pixel. All other cycles change no state, except that `valid_pool` clears.

**ReLU.** v = 0 if conv_op[31]=1; otherwise v = conv_op. All comparisons are unsigned on 32 bits, which is safe because v ≥ 0.

**Counters.**
- `col` counts 0..m-1. It increments per accepted pixel and wraps to 0.
- `row` counts 0..m-1. It increments when `col` wraps.
- The pixel at row m-1, col m-1 is the last of the map.

**Even row (row[0]=0).**
- col even: hreg <= v.
- col odd: rowbuf[col>>1] <= max(hreg, v).

**Odd row (row[0]=1).**
- col even: hreg <= v.
- col odd: `pool_op` <= max(rowbuf[col>>1], hreg, v), and `valid_pool` <= 1 on the next edge.

**Sizing.** rowbuf has m/2 entries of 32 bits. Only registers are used, so there is no read latency.

**Tie-break.** Ties in max are irrelevant because equal values are identical.

**End of map.** Accepting the last pixel sets `end_pool` <= 1 on the same edge that raises the final `valid_pool`. After that, `valid_conv` is ignored until `global_rst`.

**Gaps.** Gaps in `valid_conv`, such as the convolver's k-1-cycle wrap gaps or `ce` low, are tolerated anywhere. The counters advance only on accepted pixels.

**Reset.** Reset mid-map discards all partial state: counters, hreg, rowbuf and outputs are cleared. The first pixel accepted after reset is treated as row 0, col 0.

## Timing
**Reset values.**
- `pool_op`=0, `valid_pool`=0, `end_pool`=0.
- col=0, row=0, hreg=0, all rowbuf entries = 0.
- `global_rst` has priority over `ce` and over any accepted pixel in the same cycle.

**Latency.** Exactly 1 clock from accepting an odd-row/odd-col pixel to `valid_pool`=1 with the result on `pool_op`.

**Pulse shape.** `valid_pool` is high for exactly one cycle per result, independent of `ce`. `pool_op` holds its last value until the next result.

**Throughput.** One pixel per cycle sustained. There is no backpressure, so the downstream consumer must accept every `valid_pool` pulse.

**Output count.** (m/2)^2 results per map. This is 16 for m=8.

**End of map, cycle level.** `end_pool` rises on the same edge as the final `valid_pool` and stays 1 until reset.

## Test plan
1. **Ramp map.** m=8, continuous valid, pixel(r,c) = 8r+c, with `ce`=1 throughout. Required: 16 pulses with values 9, 11, 13, 15, 25, …, 63 (i.e. 16i+2j+9 for pooled index i,j). Each pulse arrives 1 cycle after pixel (2i+1, 2j+1). `end_pool`=1 together with the value 63 and stays 1.
2. **ReLU.** Map filled with -5 (0xFFFFFFFB), except pixel(0,0)=7 and pixel(3,3)=0x7FFFFFFF. Required: first result 7; the result for block (1,1) is 0x7FFFFFFF; every other result is 0.
3. **Convolver-style gaps.** Ramp from test 1, with 2 idle cycles after each row and `ce` toggled 1/0 every cycle. Required: the same 16 values as test 1, each `valid_pool` exactly one cycle wide, and no extra pulses.
4. **Mid-map reset.** Assert `global_rst` for 1 cycle after 20 accepted pixels, then send the full ramp from test 1. Required: no pulse during or immediately after reset, then the exact test-1 sequence with no stale rowbuf contribution.
5. **Post-end input.** After test 1, drive 10 more valid pixels of 1000. Required: `valid_pool` stays 0, `pool_op` holds 63, `end_pool` stays 1.
6. **Reset priority.** Assert `global_rst` in the same cycle that pixel (1,1)=99 is presented with valid. Required: the next cycle has `valid_pool`=0 and `pool_op`=0.
